// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: sizing, rob_item_t entry layout and helpers shared by the reorder buffer.
package reorder_buffer_pkg;

    localparam int RENAME_WIDTH        = 4;
    localparam int WB_WIDTH            = 4;
    localparam int COMMIT_WIDTH        = 4;
    localparam int ROB_SIZE            = 32;
    localparam int ROB_ID_WIDTH        = $clog2(ROB_SIZE);
    localparam int PHY_REG_ID_WIDTH    = 6;
    localparam int CHECKPOINT_ID_WIDTH = 4;
    localparam int CSR_ADDR_WIDTH      = 12;

    typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
    // One extra MSB distinguishes full from empty when the index bits match.
    typedef logic [ROB_ID_WIDTH:0] rob_ptr_t;

    typedef enum logic [3:0] {
        instruction_address_misaligned = 4'd0,
        instruction_access_fault       = 4'd1,
        illegal_instruction            = 4'd2,
        breakpoint                     = 4'd3,
        load_address_misaligned        = 4'd4,
        load_access_fault              = 4'd5,
        store_amo_address_misaligned   = 4'd6,
        store_amo_access_fault         = 4'd7,
        environment_call_from_u_mode   = 4'd8,
        environment_call_from_s_mode   = 4'd9,
        environment_call_from_m_mode   = 4'd11,
        instruction_page_fault         = 4'd12,
        load_page_fault                = 4'd13,
        store_amo_page_fault           = 4'd15
    } riscv_exception_t;

    typedef struct packed {
        logic [PHY_REG_ID_WIDTH-1:0]    new_phy_reg_id;
        logic [PHY_REG_ID_WIDTH-1:0]    old_phy_reg_id;
        logic                           old_phy_reg_id_valid;
        logic                           finish;
        logic [31:0]                    pc;
        logic [31:0]                    inst_value;
        logic                           has_exception;
        riscv_exception_t               exception_id;
        logic [31:0]                    exception_value;
        logic                           predicted;
        logic                           predicted_jump;
        logic [31:0]                    predicted_next_pc;
        logic                           checkpoint_id_valid;
        logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
        logic [3:0]                     bru_op;
        logic                           bru_jump;
        logic [31:0]                    bru_next_pc;
        logic                           is_mret;
        logic [CSR_ADDR_WIDTH-1:0]      csr_addr;
        logic [31:0]                    csr_newvalue;
        logic                           csr_newvalue_valid;
    } rob_item_t;

    function automatic rob_ptr_t lead_ones(input logic [COMMIT_WIDTH-1:0] m);
        logic run;
        lead_ones = '0;
        run = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            run = run & m[i];
            lead_ones = lead_ones + rob_ptr_t'(run);
        end
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: rename, commit/writeback, retire and flush-walk signals of the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    rob_id_t   [RENAME_WIDTH-1:0] rob_rename_new_id;
    logic      [RENAME_WIDTH-1:0] rob_rename_new_id_valid;
    rob_item_t [RENAME_WIDTH-1:0] rename_rob_data;
    logic      [RENAME_WIDTH-1:0] rename_rob_data_valid;
    logic                         rename_rob_push;

    rob_id_t   [WB_WIDTH-1:0]     commit_rob_input_id;
    rob_item_t [WB_WIDTH-1:0]     rob_commit_input_data;
    rob_item_t [WB_WIDTH-1:0]     commit_rob_input_data;
    logic      [WB_WIDTH-1:0]     commit_rob_input_data_we;

    rob_id_t                      rob_commit_retire_head_id;
    logic                         rob_commit_retire_head_id_valid;
    rob_id_t   [COMMIT_WIDTH-1:0] commit_rob_retire_id;
    rob_item_t [COMMIT_WIDTH-1:0] rob_commit_retire_data;
    logic      [COMMIT_WIDTH-1:0] rob_commit_retire_id_valid;
    logic      [COMMIT_WIDTH-1:0] commit_rob_retire_pop;

    rob_id_t                      commit_rob_next_id;
    logic                         rob_commit_next_id_valid;

    rob_id_t                      rob_commit_flush_tail_id;
    logic                         rob_commit_flush_tail_id_valid;
    rob_id_t                      commit_rob_flush_id;
    rob_item_t                    rob_commit_flush_data;
    rob_id_t                      rob_commit_flush_next_id;
    logic                         rob_commit_flush_next_id_valid;

    logic                         rob_commit_empty;
    logic                         rob_commit_full;
    logic                         commit_rob_flush;

    modport slave (
        output rob_rename_new_id, rob_rename_new_id_valid,
        input  rename_rob_data, rename_rob_data_valid, rename_rob_push,
        input  commit_rob_input_id, commit_rob_input_data, commit_rob_input_data_we,
        output rob_commit_input_data,
        output rob_commit_retire_head_id, rob_commit_retire_head_id_valid,
        input  commit_rob_retire_id, commit_rob_retire_pop,
        output rob_commit_retire_data, rob_commit_retire_id_valid,
        input  commit_rob_next_id,
        output rob_commit_next_id_valid,
        output rob_commit_flush_tail_id, rob_commit_flush_tail_id_valid,
        input  commit_rob_flush_id,
        output rob_commit_flush_data, rob_commit_flush_next_id, rob_commit_flush_next_id_valid,
        output rob_commit_empty, rob_commit_full,
        input  commit_rob_flush
    );

    modport master (
        input  rob_rename_new_id, rob_rename_new_id_valid,
        output rename_rob_data, rename_rob_data_valid, rename_rob_push,
        output commit_rob_input_id, commit_rob_input_data, commit_rob_input_data_we,
        input  rob_commit_input_data,
        input  rob_commit_retire_head_id, rob_commit_retire_head_id_valid,
        output commit_rob_retire_id, commit_rob_retire_pop,
        input  rob_commit_retire_data, rob_commit_retire_id_valid,
        output commit_rob_next_id,
        input  rob_commit_next_id_valid,
        input  rob_commit_flush_tail_id, rob_commit_flush_tail_id_valid,
        output commit_rob_flush_id,
        input  rob_commit_flush_data, rob_commit_flush_next_id, rob_commit_flush_next_id_valid,
        input  rob_commit_empty, rob_commit_full,
        output commit_rob_flush
    );

endinterface

// File: rtl/reorder_buffer_occupancy.sv
// reorder_buffer_occupancy: used/free counts, empty/full and per-id occupancy from head/tail pointers.
module reorder_buffer_occupancy
    import reorder_buffer_pkg::*;
(
    input  rob_ptr_t            head,
    input  rob_ptr_t            tail,
    output rob_ptr_t            used,
    output rob_ptr_t            free,
    output logic                empty,
    output logic                full,
    output logic [ROB_SIZE-1:0] occ
);

    assign used  = tail - head;
    assign free  = rob_ptr_t'(ROB_SIZE) - used;
    assign empty = head == tail;
    assign full  = head[ROB_ID_WIDTH-1:0] == tail[ROB_ID_WIDTH-1:0] && head[ROB_ID_WIDTH] != tail[ROB_ID_WIDTH];

    // An id is occupied when its distance from head is below the occupancy.
    for (genvar k = 0; k < ROB_SIZE; k++) begin : g_occ
        assign occ[k] = {1'b0, rob_id_t'(rob_id_t'(k) - head[ROB_ID_WIDTH-1:0])} < used;
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB with multi-lane allocate, random access, in-order retire and flush walk.
// Define ROB_CHECK_EN to compile in simulation assertions on illegal requests.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave bus
);

    rob_ptr_t                  head, tail, used, free, push_n, pop_n;
    logic                      empty, full;
    logic [ROB_SIZE-1:0]       occ;
    logic [RENAME_WIDTH-1:0]   push_lane;
    rob_id_t                   head_idx, tail_idx;
    rob_item_t                 entries [ROB_SIZE];

    assign head_idx = head[ROB_ID_WIDTH-1:0];
    assign tail_idx = tail[ROB_ID_WIDTH-1:0];

    reorder_buffer_occupancy u_occupancy (
        .head  (head),
        .tail  (tail),
        .used  (used),
        .free  (free),
        .empty (empty),
        .full  (full),
        .occ   (occ)
    );

    always_comb begin
        push_n = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            bus.rob_rename_new_id[i]       = tail_idx + rob_id_t'(i);
            bus.rob_rename_new_id_valid[i] = free > rob_ptr_t'(i);
            push_lane[i] = bus.rename_rob_push && bus.rename_rob_data_valid[i] && free > rob_ptr_t'(i);
            push_n = push_n + rob_ptr_t'(push_lane[i]);
        end
        pop_n = lead_ones(bus.commit_rob_retire_pop) > used ? used : lead_ones(bus.commit_rob_retire_pop);
        for (int j = 0; j < WB_WIDTH; j++)
            bus.rob_commit_input_data[j] = entries[bus.commit_rob_input_id[j]];
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            bus.rob_commit_retire_data[i]     = entries[bus.commit_rob_retire_id[i]];
            bus.rob_commit_retire_id_valid[i] = occ[bus.commit_rob_retire_id[i]];
        end
    end

    assign bus.rob_commit_retire_head_id       = head_idx;
    assign bus.rob_commit_retire_head_id_valid = !empty;
    assign bus.rob_commit_next_id_valid        = occ[bus.commit_rob_next_id] && bus.commit_rob_next_id != head_idx;
    assign bus.rob_commit_flush_tail_id        = tail_idx - 1'b1;
    assign bus.rob_commit_flush_tail_id_valid  = !empty;
    assign bus.rob_commit_flush_data           = entries[bus.commit_rob_flush_id];
    assign bus.rob_commit_flush_next_id        = bus.commit_rob_flush_id - 1'b1;
    assign bus.rob_commit_flush_next_id_valid  = occ[bus.commit_rob_flush_id] && bus.commit_rob_flush_id != head_idx;
    assign bus.rob_commit_empty                = empty;
    assign bus.rob_commit_full                 = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (bus.commit_rob_flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + pop_n;
            tail <= tail + push_n;
        end
    end

    // Commit writes follow allocation writes, so the highest commit lane wins any id clash.
    always_ff @(posedge clk) begin
        if (!bus.commit_rob_flush) begin
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (push_lane[i]) entries[bus.rob_rename_new_id[i]] <= bus.rename_rob_data[i];
            for (int j = 0; j < WB_WIDTH; j++)
                if (bus.commit_rob_input_data_we[j]) entries[bus.commit_rob_input_id[j]] <= bus.commit_rob_input_data[j];
        end
    end

`ifdef ROB_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst && !bus.commit_rob_flush) begin
            assert (!bus.rename_rob_push || (bus.rename_rob_data_valid & ~bus.rob_rename_new_id_valid) == '0);
            assert (lead_ones(bus.commit_rob_retire_pop) <= used);
            assert ((bus.rename_rob_data_valid & (bus.rename_rob_data_valid + 1'b1)) == '0);
            assert ((bus.commit_rob_retire_pop & (bus.commit_rob_retire_pop + 1'b1)) == '0);
            for (int j = 0; j < WB_WIDTH; j++)
                assert (!bus.commit_rob_input_data_we[j] || occ[bus.commit_rob_input_id[j]]);
        end
    end
`else
    // Checks compiled out.
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a count/queue-style model compared every cycle plus literal checks.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    reorder_buffer_if bus ();

    reorder_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    rob_item_t mem [32];
    bit        mw [32];
    int        mhead = 0;
    int        mcount = 0;

    function automatic rob_item_t mk(input logic [31:0] pc, input logic [31:0] ev);
        rob_item_t r;
        r = '0;
        r.pc = pc;
        r.inst_value = ~pc;
        r.exception_value = ev;
        r.new_phy_reg_id = pc[5:0];
        r.csr_newvalue = pc ^ ev;
        return r;
    endfunction

    function automatic bit occ_m(input int id);
        return ((id - mhead + 32) % 32) < mcount;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mhead = 0;
            mcount = 0;
        end else if (bus.commit_rob_flush) begin
            mhead = 0;
            mcount = 0;
        end else begin
            int pushed, pops, idx;
            pushed = 0;
            if (bus.rename_rob_push)
                for (int i = 0; i < 4; i++)
                    if (bus.rename_rob_data_valid[i] && i < 32 - mcount) begin
                        idx = (mhead + mcount + i) % 32;
                        mem[idx] = bus.rename_rob_data[i];
                        mw[idx] = 1'b1;
                        pushed++;
                    end
            for (int j = 0; j < 4; j++)
                if (bus.commit_rob_input_data_we[j]) begin
                    mem[bus.commit_rob_input_id[j]] = bus.commit_rob_input_data[j];
                    mw[bus.commit_rob_input_id[j]] = 1'b1;
                end
            pops = 0;
            for (int i = 0; i < 4; i++) begin
                if (!bus.commit_rob_retire_pop[i]) break;
                pops++;
            end
            if (pops > mcount) pops = mcount;
            mhead = (mhead + pops) % 32;
            mcount = mcount + pushed - pops;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("new_id[%0d]", i), bus.rob_rename_new_id[i], (mhead + mcount + i) % 32);
                chk($sformatf("new_id_valid[%0d]", i), bus.rob_rename_new_id_valid[i], 32 - mcount > i);
                if (mw[bus.commit_rob_input_id[i]])
                    chk($sformatf("input_data[%0d]", i), bus.rob_commit_input_data[i], mem[bus.commit_rob_input_id[i]]);
                chk($sformatf("retire_id_valid[%0d]", i), bus.rob_commit_retire_id_valid[i], occ_m(bus.commit_rob_retire_id[i]));
                if (mw[bus.commit_rob_retire_id[i]])
                    chk($sformatf("retire_data[%0d]", i), bus.rob_commit_retire_data[i], mem[bus.commit_rob_retire_id[i]]);
            end
            chk("head_id", bus.rob_commit_retire_head_id, mhead);
            chk("head_id_valid", bus.rob_commit_retire_head_id_valid, mcount != 0);
            chk("next_id_valid", bus.rob_commit_next_id_valid,
                occ_m(bus.commit_rob_next_id) && bus.commit_rob_next_id != mhead);
            chk("flush_tail_id", bus.rob_commit_flush_tail_id, (mhead + mcount + 31) % 32);
            chk("flush_tail_id_valid", bus.rob_commit_flush_tail_id_valid, mcount != 0);
            if (mw[bus.commit_rob_flush_id])
                chk("flush_data", bus.rob_commit_flush_data, mem[bus.commit_rob_flush_id]);
            chk("flush_next_id", bus.rob_commit_flush_next_id, (bus.commit_rob_flush_id + 31) % 32);
            chk("flush_next_id_valid", bus.rob_commit_flush_next_id_valid,
                occ_m(bus.commit_rob_flush_id) && bus.commit_rob_flush_id != mhead);
            chk("empty", bus.rob_commit_empty, mcount == 0);
            chk("full", bus.rob_commit_full, mcount == 32);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rename_rob_push = 1'b0;
        bus.rename_rob_data_valid = '0;
        bus.rename_rob_data = '0;
        bus.commit_rob_input_id = '0;
        bus.commit_rob_input_data = '0;
        bus.commit_rob_input_data_we = '0;
        bus.commit_rob_retire_id = '0;
        bus.commit_rob_retire_pop = '0;
        bus.commit_rob_next_id = '0;
        bus.commit_rob_flush_id = '0;
        bus.commit_rob_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk("rst new_id", bus.rob_rename_new_id[i], i);
        chk("rst new_id_valid", bus.rob_rename_new_id_valid, 4'hf);
        chk("rst empty", bus.rob_commit_empty, 1'b1);
        chk("rst full", bus.rob_commit_full, 1'b0);
        chk("rst head_valid", bus.rob_commit_retire_head_id_valid, 1'b0);
        chk("rst tail_valid", bus.rob_commit_flush_tail_id_valid, 1'b0);

        // two 4-lane allocations
        bus.rename_rob_push = 1'b1;
        bus.rename_rob_data_valid = 4'hf;
        for (int i = 0; i < 4; i++) bus.rename_rob_data[i] = mk(32'habcdefac + i, 0);
        tick();
        #1;
        for (int i = 0; i < 4; i++) chk("alloc1 new_id", bus.rob_rename_new_id[i], 4 + i);
        tick();
        bus.rename_rob_push = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk("alloc2 new_id", bus.rob_rename_new_id[i], 8 + i);
        chk("alloc empty", bus.rob_commit_empty, 1'b0);

        // random read, write, retire read
        for (int i = 0; i < 4; i++) bus.commit_rob_input_id[i] = rob_id_t'(i);
        #1;
        for (int i = 0; i < 4; i++) chk("read pc", bus.rob_commit_input_data[i].pc, 32'habcdefac + i);
        for (int i = 0; i < 4; i++) bus.commit_rob_input_data[i] = mk(32'habcdefac + i, 32'b1001 + i);
        bus.commit_rob_input_data_we = 4'hf;
        tick();
        bus.commit_rob_input_data_we = '0;
        #1;
        for (int i = 0; i < 4; i++) chk("write readback", bus.rob_commit_input_data[i].exception_value, 32'b1001 + i);
        for (int i = 0; i < 4; i++) bus.commit_rob_retire_id[i] = rob_id_t'(i);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("retire pc", bus.rob_commit_retire_data[i].pc, 32'habcdefac + i);
            chk("retire valid", bus.rob_commit_retire_id_valid[i], 1'b1);
        end

        // flush walk and next_id
        chk("tail_id", bus.rob_commit_flush_tail_id, 7);
        for (int i = 7; i >= 0; i--) begin
            bus.commit_rob_flush_id = rob_id_t'(i);
            #1;
            chk("walk pc", bus.rob_commit_flush_data.pc, 32'habcdefac + (i % 4));
            chk("walk next_id", bus.rob_commit_flush_next_id, (i + 31) % 32);
            chk("walk next_valid", bus.rob_commit_flush_next_id_valid, i != 0);
        end
        bus.commit_rob_next_id = 5'd0;
        #1 chk("next_id 0", bus.rob_commit_next_id_valid, 1'b0);
        bus.commit_rob_next_id = 5'd7;
        #1 chk("next_id 7", bus.rob_commit_next_id_valid, 1'b1);
        bus.commit_rob_next_id = 5'd8;
        #1 chk("next_id 8", bus.rob_commit_next_id_valid, 1'b0);

        // single-lane retire
        tick();
        bus.commit_rob_retire_pop = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1 chk("pop head_id", bus.rob_commit_retire_head_id, k);
            tick();
        end
        bus.commit_rob_retire_pop = '0;
        #1 chk("drained empty", bus.rob_commit_empty, 1'b1);

        // push then flush, then push and flush together
        bus.rename_rob_push = 1'b1;
        for (int i = 0; i < 4; i++) bus.rename_rob_data[i] = mk(32'h1000 + i, 0);
        tick();
        bus.rename_rob_push = 1'b0;
        #1 chk("pre-flush empty", bus.rob_commit_empty, 1'b0);
        bus.commit_rob_flush = 1'b1;
        tick();
        bus.commit_rob_flush = 1'b0;
        #1 chk("flush empty", bus.rob_commit_empty, 1'b1);
        chk("flush new_id", bus.rob_rename_new_id[0], 0);
        bus.rename_rob_push = 1'b1;
        bus.commit_rob_flush = 1'b1;
        tick();
        bus.rename_rob_push = 1'b0;
        bus.commit_rob_flush = 1'b0;
        #1 chk("flush beats push", bus.rob_commit_empty, 1'b1);

        // fill with single lanes, overflow push, then drain 4 per cycle
        bus.rename_rob_push = 1'b1;
        bus.rename_rob_data_valid = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            bus.rename_rob_data[0] = mk(32'h2000 + k, k);
            tick();
        end
        #1 chk("fill full", bus.rob_commit_full, 1'b1);
        chk("fill new_id_valid", bus.rob_rename_new_id_valid, 4'h0);
        bus.rename_rob_data_valid = 4'hf;
        tick();
        bus.rename_rob_push = 1'b0;
        #1 chk("overflow full", bus.rob_commit_full, 1'b1);
        chk("overflow head", bus.rob_commit_retire_head_id, 0);
        bus.commit_rob_retire_pop = 4'hf;
        for (int c = 0; c < 8; c++) begin
            #1 chk("drain not empty", bus.rob_commit_empty, 1'b0);
            tick();
        end
        bus.commit_rob_retire_pop = '0;
        #1 chk("drain empty", bus.rob_commit_empty, 1'b1);

        // two lanes, write clash, clipped pop, push with pop on empty
        bus.rename_rob_push = 1'b1;
        bus.rename_rob_data_valid = 4'b0011;
        for (int i = 0; i < 4; i++) bus.rename_rob_data[i] = mk(32'h3000 + i, 0);
        tick();
        bus.rename_rob_push = 1'b0;
        bus.commit_rob_input_id = '0;
        bus.commit_rob_input_data[0] = mk(32'h4444, 1);
        bus.commit_rob_input_data[1] = mk(32'h5555, 2);
        bus.commit_rob_input_data_we = 4'b0011;
        tick();
        bus.commit_rob_input_data_we = '0;
        #1 chk("clash winner", bus.rob_commit_input_data[0].pc, 32'h5555);
        bus.commit_rob_retire_pop = 4'hf;
        tick();
        bus.commit_rob_retire_pop = '0;
        #1 chk("clip empty", bus.rob_commit_empty, 1'b1);
        chk("clip head", bus.rob_commit_retire_head_id, 2);
        bus.rename_rob_push = 1'b1;
        bus.rename_rob_data_valid = 4'b0111;
        bus.commit_rob_retire_pop = 4'b0001;
        tick();
        bus.rename_rob_push = 1'b0;
        bus.commit_rob_retire_pop = '0;
        #1 chk("push+pop head", bus.rob_commit_retire_head_id, 2);
        chk("push+pop tail", bus.rob_commit_flush_tail_id, 4);
        chk("push+pop new_id", bus.rob_rename_new_id[0], 5);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
